// File: rtl/ram_bank.sv
// Word-addressed RAM with a memory address register, set/enable bus semantics,
// MAR auto-increment, a background zero-fill engine and ungated monitor taps.
module ram_bank #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  bus_in,
  input  logic              mar_set,
  input  logic              ram_set,
  input  logic              ram_en,
  input  logic              auto_inc,
  input  logic              clear_req,
  output logic [WIDTH-1:0]  bus_out,
  output logic              busy,
  output logic [ADDR_W-1:0] mar_monitor,
  output logic [WIDTH-1:0]  data_monitor
);
  localparam int DEPTH = 2**ADDR_W;

  // The MAR is loaded from the data bus, so it cannot be wider than a word.
  generate
    if (ADDR_W > WIDTH) begin : g_bad_params
      $error("ram_bank: ADDR_W (%0d) must not exceed WIDTH (%0d)", ADDR_W, WIDTH);
    end
  endgenerate

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (mar_set)
          mar_d = bus_in[ADDR_W-1:0];
        else if (auto_inc && (ram_set || ram_en))
          mar_d = mar_q + 1'b1;
        if (clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        // Pointer wraps back to zero on the final word, ready for the next clear.
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage is deliberately not reset; the clear engine is the way to zero it.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem[ptr_q] <= '0;
    else if (ram_set)
      mem[mar_q] <= bus_in;
  end

  assign busy         = (state_q == CLEAR);
  assign mar_monitor  = mar_q;
  assign data_monitor = mem[mar_q];
  // AND-gating keeps bus_out a clean zero even if the array holds unknowns.
  assign bus_out      = data_monitor & {WIDTH{ram_en && !busy}};

endmodule

// File: tb/tb_ram_bank.sv
// Scoreboard bench for ram_bank: 8x256 default instance plus a 16x16 instance.
module tb_ram_bank;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  bi = '0;
  logic        ms = 0, rs = 0, re = 0, ai = 0, cr = 0;
  logic [7:0]  bo, dm, mar;
  logic        bsy;

  logic [15:0] b_bi = '0;
  logic        b_ms = 0, b_rs = 0, b_re = 0, b_ai = 0, b_cr = 0;
  logic [15:0] b_bo, b_dm;
  logic [3:0]  b_mar;
  logic        b_bsy;

  ram_bank #(.WIDTH(8), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .bus_in(bi), .mar_set(ms), .ram_set(rs),
    .ram_en(re), .auto_inc(ai), .clear_req(cr), .bus_out(bo), .busy(bsy),
    .mar_monitor(mar), .data_monitor(dm));

  ram_bank #(.WIDTH(16), .ADDR_W(4)) dut2 (
    .clk(clk), .reset(reset), .bus_in(b_bi), .mar_set(b_ms), .ram_set(b_rs),
    .ram_en(b_re), .auto_inc(b_ai), .clear_req(b_cr), .bus_out(b_bo), .busy(b_bsy),
    .mar_monitor(b_mar), .data_monitor(b_dm));

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sample(int sel);
    case (sel)
      0: return {8'h00, bo};
      1: return {8'h00, dm};
      2: return {8'h00, mar};
      3: return {15'h0, bsy};
      4: return b_bo;
      5: return b_dm;
      6: return {12'h0, b_mar};
      default: return {15'h0, b_bsy};
    endcase
  endfunction

  // Monitor: compares every expectation stamped for the current cycle.
  always @(negedge clk) begin
    exp_t x;
    logic [15:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      x = sb.pop_front();
      act = sample(x.sel);
      n_tests++;
      if (x.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation not sampled in its cycle (%0d vs %0d)", x.nm, x.cyc, cyc);
      end else if (act !== x.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", x.nm, act, x.exp, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(int sel, logic [15:0] e, string nm);
    sb.push_back('{cyc, sel, e, nm});
  endtask

  task automatic wr8(logic [7:0] a, logic [7:0] d);
    ms = 1; bi = a; tick();
    ms = 0; rs = 1; bi = d; tick();
    rs = 0;
  endtask

  task automatic rd8(logic [7:0] a, logic [7:0] e, string nm);
    ms = 1; bi = a; tick();
    ms = 0;
    chk(1, {8'h00, e}, nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    chk(2, 0, "rst_mar"); chk(3, 0, "rst_busy"); chk(0, 0, "rst_bus_out");
    chk(6, 0, "rst_mar2"); chk(7, 0, "rst_busy2");
    reset = 0; tick();

    // Basic set/enable
    ms = 1; bi = 8'h10; tick();
    ms = 0; chk(2, 16'h10, "mar_load");
    rs = 1; bi = 8'hA5; tick();
    rs = 0; re = 1; chk(0, 16'hA5, "read_en");
    tick();
    re = 0; chk(0, 16'h00, "read_gated"); chk(1, 16'hA5, "data_mon"); chk(2, 16'h10, "mar_no_inc");

    // Auto-increment across the wrap
    ms = 1; bi = 8'hFE; tick();
    ms = 0; ai = 1; rs = 1; bi = 8'h11; tick();
    bi = 8'h22; tick();
    rs = 0; ai = 0; chk(2, 16'h00, "wrap_mar");
    ms = 1; bi = 8'hFE; tick();
    ms = 0; re = 1; ai = 1;
    chk(0, 16'h11, "rd_fe"); chk(2, 16'hFE, "rd_mar_fe"); tick();
    chk(0, 16'h22, "rd_ff"); chk(2, 16'hFF, "rd_mar_ff"); tick();
    chk(2, 16'h00, "rd_mar_wrap");
    re = 0; ai = 0;

    // Simultaneous write + read, mar_set beats auto_inc
    wr8(8'h05, 8'h3C);
    rs = 1; re = 1; bi = 8'hC3;
    chk(0, 16'h3C, "rw_old"); tick();
    rs = 0;
    chk(0, 16'hC3, "rw_new"); chk(2, 16'h05, "rw_mar");
    ms = 1; ai = 1; re = 1; bi = 8'h40; tick();
    ms = 0; ai = 0; re = 0;
    chk(2, 16'h40, "mar_set_prio");

    // Full clear with ignored traffic while busy
    wr8(8'h20, 8'h5A);
    cr = 1; tick();
    cr = 0;
    for (int i = 0; i < 256; i++) begin
      chk(3, 1, "clr_busy");
      if (i == 5)  chk(1, 16'h5A, "clr_mid_old");
      if (i == 40) chk(1, 16'h00, "clr_mid_zero");
      if (i == 10) begin re = 1; rs = 1; ai = 1; cr = 1; bi = 8'hEE; end
      if (i == 12) begin ms = 1; bi = 8'h99; end
      if (i >= 10 && i <= 12) chk(0, 0, "clr_bus_gated");
      if (i >= 11 && i <= 13) chk(2, 16'h20, "clr_mar_held");
      if (i == 13) begin re = 0; rs = 0; ai = 0; cr = 0; ms = 0; bi = 8'h00; end
      tick();
    end
    chk(3, 0, "clr_done"); chk(2, 16'h20, "clr_mar_after");
    ms = 1; bi = 8'h00; tick();
    ms = 0; re = 1; ai = 1;
    for (int i = 0; i < 256; i++) begin
      chk(0, 0, "clr_word_zero");
      tick();
    end
    re = 0; ai = 0;

    // Reset aborts an in-progress clear
    wr8(8'h10, 8'h99);
    wr8(8'h64, 8'h64);
    wr8(8'h80, 8'h77);
    ms = 1; bi = 8'h33; tick();
    ms = 0; cr = 1; tick();
    cr = 0;
    repeat (100) tick();
    reset = 1;
    chk(3, 0, "abort_busy"); chk(2, 0, "abort_mar");
    tick();
    reset = 0; tick();
    chk(3, 0, "abort_idle");
    rd8(8'h10, 8'h00, "abort_cleared_10");
    rd8(8'h63, 8'h00, "abort_cleared_63");
    rd8(8'h64, 8'h64, "abort_kept_64");
    rd8(8'h80, 8'h77, "abort_kept_80");

    // 16-bit word, 4-bit address instance
    b_ms = 1; b_bi = 16'hABC5; tick();
    b_ms = 0; chk(6, 16'h5, "p_mar_trunc");
    b_ms = 1; b_bi = 16'h000F; tick();
    b_ms = 0; b_rs = 1; b_ai = 1; b_bi = 16'h1234; tick();
    b_rs = 0; b_ai = 0; chk(6, 16'h0, "p_wrap");
    b_ms = 1; b_bi = 16'h000F; tick();
    b_ms = 0; b_re = 1; chk(4, 16'h1234, "p_read");
    tick();
    b_re = 0;
    b_cr = 1; tick();
    for (int i = 0; i < 16; i++) begin
      chk(7, 1, "p_clr_busy");
      tick();
    end
    chk(7, 0, "p_clr_done"); chk(5, 16'h0000, "p_clr_zero");
    tick();
    chk(7, 1, "p_clr_restart");
    b_cr = 0;
    repeat (16) tick();
    chk(7, 0, "p_clr_done2");

    tick(); tick();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_bank.md
Name: ram_bank

Overview:
- Parametrised, clocked successor to the gate-level byte/register storage: a WIDTH-bit by 2**ADDR_W-word RAM with a memory address register (MAR).
- Uses the same set/enable bus semantics as the existing registers: set captures from bus_in, enable drives bus_out, and bus_out is all-zero when not enabled.
- Adds address auto-increment, a hardware clear engine with busy status, and monitor taps.
- Sits on the CPU data bus as main memory.

Parameters:
WIDTH, 8, data word width in bits
ADDR_W, 8, address width; depth = 2**ADDR_W words; ADDR_W <= WIDTH required (elaboration error otherwise)

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  asynchronous, active-high reset
bus_in  in  WIDTH  data/address from bus
mar_set  in  1  load MAR from bus_in[ADDR_W-1:0]
ram_set  in  1  write bus_in to mem[MAR]
ram_en  in  1  drive mem[MAR] onto bus_out
auto_inc  in  1  post-increment MAR after an access
clear_req  in  1  start zero-fill of whole array
bus_out  out  WIDTH  gated read data; 0 when not enabled
busy  out  1  clear engine active
mar_monitor  out  ADDR_W  current MAR, ungated
data_monitor  out  WIDTH  mem[MAR], ungated

Behaviour:
- Reset (async, active-high): MAR=0, state=IDLE, clear pointer=0, busy=0. bus_out=0 unless ram_en. Memory array is NOT reset; use clear_req to zero it.
- FSM states:
  - IDLE: normal access.
  - CLEAR: zero-fill.
- IDLE, each rising edge:
  - mar_set=1: MAR <= bus_in[ADDR_W-1:0].
  - ram_set=1: mem[MAR] <= bus_in, using the MAR value before this edge.
  - auto_inc=1 and (ram_set or ram_en) and mar_set=0: MAR <= MAR+1, modulo 2**ADDR_W (wrap at 2**ADDR_W-1 to 0).
  - mar_set has priority over auto-increment.
  - mar_set and ram_set in the same cycle: the write uses the old MAR, then MAR loads the new value.
- Read path is combinational with zero added latency:
  - bus_out = ram_en ? mem[MAR] : 0, as a per-bit AND with ram_en.
  - data_monitor = mem[MAR] always.
  - mar_monitor = MAR always.
- ram_set and ram_en together: legal. bus_out shows the pre-write contents during that cycle; the new value is visible from the next cycle.
- Entering CLEAR: clear_req=1 in IDLE at an edge. The same edge sets state=CLEAR, pointer=0, busy=1. Any mar_set/ram_set/auto_inc in that cycle are still honoured.
- In CLEAR, each edge:
  - mem[pointer] <= 0, pointer <= pointer+1.
  - When pointer==2**ADDR_W-1, the final write occurs, state returns to IDLE and busy falls.
  - busy is high for exactly 2**ADDR_W cycles.
- While busy:
  - mar_set, ram_set, auto_inc and clear_req are ignored.
  - MAR is preserved.
  - bus_out is forced to 0 even if ram_en=1.
  - data_monitor shows mem[MAR], which may be mid-clear.
- Reset during CLEAR: aborts immediately. State=IDLE, busy=0, MAR=0. Already-cleared words stay zero; the rest keep their old contents.
- clear_req held high continuously: the next clear starts only from IDLE, i.e. on the edge after busy falls.
- No X on bus_out when ram_en=0, regardless of memory contents.

Test Plan:
- Reset, then mar_set with bus_in=0x10 -> mar_monitor=0x10 next cycle. ram_set with bus_in=0xA5 -> after edge, ram_en=1 gives bus_out=0xA5; ram_en=0 gives bus_out=0x00 and data_monitor=0xA5.
- Auto-increment across wrap: MAR=0xFE, auto_inc=1, write 0x11 then 0x22 -> mem[0xFE]=0x11, mem[0xFF]=0x22, MAR=0x00. Reading back with auto_inc traverses 0xFE, 0xFF, 0x00.
- Simultaneous access: MAR=0x05, mem[0x05]=0x3C, ram_set=ram_en=1, bus_in=0xC3 -> bus_out=0x3C in that cycle, 0xC3 the next cycle. mar_set with auto_inc=1 in the same cycle -> MAR takes the bus_in value, no increment.
- Clear: fill several locations, pulse clear_req -> busy high exactly 256 cycles. During busy, ram_en gives bus_out=0 and ram_set is ignored with MAR unchanged. After busy falls, all 256 words read 0x00.
- Reset mid-clear: assert reset at clear cycle 100 -> busy=0 and MAR=0 immediately. Words 0x00-0x63 read 0; a word written earlier at 0x80 (0x77) still reads 0x77.
- Parameter sweep (WIDTH=16, ADDR_W=4): wrap at 0xF->0x0; mar_set uses bus_in[3:0] only (bus_in=0xABC5 -> MAR=0x5); clear takes 16 cycles.
